adc_sample_conditioner: RTL

Front-end stage between the ADC capture interface and `voltage_scale`. Decimates the raw 12-bit ADC sample stream by a power of two chosen by the timebase setting, registers each kept sample as the display sample, computes a block mean over a fixed window of kept samples, and flags rising crossings of the trigger level. Its `DATA_OUT` and `MEAN` drive the sample and mean inputs of `voltage_scale`. `TRIG_HIT` goes to the display capture logic.

---
 rtl/scope_pkg.sv | 16 +
 rtl/sample_decimator.sv | 35 +++
 rtl/adc_sample_conditioner.sv | 84 ++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared scope front-end types and constants; also used by voltage_scale and the display logic.
package scope_pkg;

    localparam int SAMPLE_W      = 12;
    localparam int MEAN_AVG_LOG2 = 8;
    localparam int DEC_W         = 3;
    localparam int DEC_CNT_W     = 7;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Terminal count of the decimation counter for a factor of 2^sel.
    function automatic logic [DEC_CNT_W-1:0] dec_mask(input logic [DEC_W-1:0] sel);
        return ~(7'h7f << sel);
    endfunction

endpackage

// File: rtl/sample_decimator.sv
// Power-of-two decimator: raises KEEP on every 2^DEC_SEL-th valid sample and
// raises CLR for the single cycle in which a new DEC_SEL value is adopted.
module sample_decimator
    import scope_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ADC_VALID,
    input  logic [DEC_W-1:0] DEC_SEL,
    output logic             KEEP,
    output logic             CLR
);

    logic [DEC_W-1:0]     dec_sel_q;
    logic [DEC_CNT_W-1:0] cnt;

    // The change cycle keeps nothing; the registered copy rules the keep test.
    assign CLR  = (dec_sel_q != DEC_SEL);
    assign KEEP = ADC_VALID && !CLR && (cnt == dec_mask(dec_sel_q));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dec_sel_q <= '0;
            cnt       <= '0;
        end else begin
            dec_sel_q <= DEC_SEL;
            if (CLR || KEEP) begin
                cnt <= '0;
            end else if (ADC_VALID) begin
                cnt <= cnt + 7'd1;
            end
        end
    end

endmodule

// File: rtl/adc_sample_conditioner.sv
// ADC front end: decimates the raw stream, publishes kept samples, a block mean
// over 2^AVG_LOG2 kept samples, and rising trigger-level crossings.
module adc_sample_conditioner
    import scope_pkg::*;
#(
    parameter int DW       = SAMPLE_W,
    parameter int AVG_LOG2 = MEAN_AVG_LOG2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ADC_VALID,
    input  logic [DW-1:0]    ADC_DATA,
    input  logic [DEC_W-1:0] DEC_SEL,
    input  logic [DW-1:0]    TRIG,
    input  logic             TRIG_EN,
    output logic [DW-1:0]    DATA_OUT,
    output logic             DATA_VALID,
    output logic [DW-1:0]    MEAN,
    output logic             MEAN_VALID,
    output logic             TRIG_HIT
);

    localparam int ACC_W = DW + AVG_LOG2;

    logic                keep;
    logic                clr;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] win_cnt;
    logic [DW-1:0]       prev;
    logic                prev_ok;

    sample_decimator u_decimator (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ADC_VALID (ADC_VALID),
        .DEC_SEL   (DEC_SEL),
        .KEEP      (keep),
        .CLR       (clr)
    );

    assign acc_sum = acc + ACC_W'(ADC_DATA);

    // Streaming outputs carry no ready: every DATA_VALID/MEAN_VALID pulse is
    // final and downstream must take it on the cycle it is high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            MEAN       <= '0;
            MEAN_VALID <= 1'b0;
            TRIG_HIT   <= 1'b0;
            acc        <= '0;
            win_cnt    <= '0;
            prev       <= '0;
            prev_ok    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            MEAN_VALID <= 1'b0;
            TRIG_HIT   <= 1'b0;
            if (clr) begin
                acc     <= '0;
                win_cnt <= '0;
                prev_ok <= 1'b0;
            end else if (keep) begin
                DATA_OUT   <= ADC_DATA;
                DATA_VALID <= 1'b1;
                TRIG_HIT   <= TRIG_EN && prev_ok && (prev < TRIG) && (ADC_DATA >= TRIG);
                prev       <= ADC_DATA;
                prev_ok    <= 1'b1;
                win_cnt    <= win_cnt + AVG_LOG2'(1);
                // The completing sample is folded into the mean it closes.
                if (win_cnt == '1) begin
                    MEAN       <= acc_sum[ACC_W-1:AVG_LOG2];
                    MEAN_VALID <= 1'b1;
                    acc        <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule
